// File: rtl/mpmc9_cache_reader.sv
// mpmc9_cache_reader: sequences one line read through cache port 0. A miss
// requests a line fill from the memory controller. After each fill the lookup
// is retried. When the retries are used up, an error response is returned.
// Optional fill watchdog: define MPMC9_RDR_TIMEOUT_EN (limit set by FILL_TIMEOUT).

package mpmc9_pkg;
  localparam int unsigned LINE_TAG_W = 20;
  localparam int unsigned LINE_DAT_W = 512;

  typedef struct packed {
    logic [LINE_TAG_W-1:0] tag;
    logic [LINE_DAT_W-1:0] data;
  } mpmc9_cache_line_t;
endpackage

module mpmc9_cache_reader
  import mpmc9_pkg::*;
#(
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned FILL_TIMEOUT = 1023
) (
  input  logic              rclk0,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_adr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output mpmc9_cache_line_t resp_dat,
  output logic              resp_err,
  output logic [31:0]       radr0,
  input  mpmc9_cache_line_t rdat0,
  input  logic              hit0,
  output logic              fill_req,
  output logic [31:0]       fill_adr,
  input  logic              fill_ack
);

  localparam int unsigned ADR_W    = 32;
  localparam int unsigned LINE_LSB = 6;
  localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOOK1 = 3'd1,
    S_LOOK2 = 3'd2,
    S_CHECK = 3'd3,
    S_FILL  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t            r_state, w_state_n;
  logic [ADR_W-1:0]  r_adr, w_adr_n;
  logic [RETRY_W-1:0] r_retry, w_retry_n;
  mpmc9_cache_line_t r_dat, w_dat_n;
  logic              r_err, w_err_n;
  logic              r_req_ready, w_req_ready_n;
  logic              r_resp_valid, w_resp_valid_n;
  logic [ADR_W-1:0]  r_radr, w_radr_n;
  logic              r_fill_req, w_fill_req_n;
  logic [ADR_W-1:0]  r_fill_adr, w_fill_adr_n;
  logic              w_look_n;
  logic              w_last_try;

  // Elaboration guard: a zero watchdog limit is meaningless
  if (FILL_TIMEOUT == 0) begin : g_bad_timeout
    $error("mpmc9_cache_reader: FILL_TIMEOUT must be at least 1");
  end

  assign w_last_try = (r_retry == RETRY_W'(MAX_RETRY));

`ifdef MPMC9_RDR_TIMEOUT_EN
  localparam int unsigned WD_W = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

  logic [WD_W-1:0] r_wdog, w_wdog_n;
  logic            w_timeout;

  assign w_timeout = (r_wdog == WD_W'(FILL_TIMEOUT - 1));

  // Watchdog counts cycles spent in FILL and restarts at zero on every entry
  always_comb begin
    w_wdog_n = '0;
    if (r_state == S_FILL && w_state_n == S_FILL) w_wdog_n = r_wdog + WD_W'(1);
  end

  // Watchdog register
  always_ff @(posedge rclk0) begin
    if (rst) r_wdog <= '0;
    else     r_wdog <= w_wdog_n;
  end
`endif

  // State register
  always_ff @(posedge rclk0) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_n = S_LOOK1;
      S_LOOK1: w_state_n = S_LOOK2;
      S_LOOK2: w_state_n = S_CHECK;
      S_CHECK: w_state_n = (!hit0 && !w_last_try) ? S_FILL : S_RESP;
      S_FILL: begin
        if (fill_ack) w_state_n = S_LOOK1;
`ifdef MPMC9_RDR_TIMEOUT_EN
        else if (w_timeout) w_state_n = S_RESP;
`endif
      end
      S_RESP:  if (resp_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    w_adr_n   = r_adr;
    w_retry_n = r_retry;
    w_dat_n   = r_dat;
    w_err_n   = r_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_adr_n   = req_adr;
          w_retry_n = '0;
        end
      end
      S_CHECK: begin
        if (hit0) begin
          w_dat_n = rdat0;
          w_err_n = 1'b0;
        end else if (!w_last_try) begin
          w_retry_n = r_retry + RETRY_W'(1);
        end else begin
          w_dat_n = '0;
          w_err_n = 1'b1;
        end
      end
`ifdef MPMC9_RDR_TIMEOUT_EN
      S_FILL: begin
        if (!fill_ack && w_timeout) begin
          w_dat_n = '0;
          w_err_n = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    w_req_ready_n  = (w_state_n == S_IDLE);
    w_resp_valid_n = (w_state_n == S_RESP);
    w_look_n       = (w_state_n inside {S_LOOK1, S_LOOK2, S_CHECK});
    w_radr_n       = w_look_n ? w_adr_n : '0;
    w_fill_req_n   = (w_state_n == S_FILL);
    w_fill_adr_n   = w_fill_req_n ? {w_adr_n[ADR_W-1:LINE_LSB], LINE_LSB'(0)} : '0;
  end

  // Datapath and output registers
  always_ff @(posedge rclk0) begin
    if (rst) begin
      r_adr        <= '0;
      r_retry      <= '0;
      r_dat        <= '0;
      r_err        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_radr       <= '0;
      r_fill_req   <= 1'b0;
      r_fill_adr   <= '0;
    end else begin
      r_adr        <= w_adr_n;
      r_retry      <= w_retry_n;
      r_dat        <= w_dat_n;
      r_err        <= w_err_n;
      r_req_ready  <= w_req_ready_n;
      r_resp_valid <= w_resp_valid_n;
      r_radr       <= w_radr_n;
      r_fill_req   <= w_fill_req_n;
      r_fill_adr   <= w_fill_adr_n;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_dat   = r_dat;
  assign resp_err   = r_err;
  assign radr0      = r_radr;
  assign fill_req   = r_fill_req;
  assign fill_adr   = r_fill_adr;

endmodule
